// File: rtl/lt24_bus_arbiter.sv
// LT24 8080-style write-bus arbiter: CPU command port vs. frame pixel stream.
// Commands own the bus per transfer, the pixel stream per whole frame.
module lt24_bus_arbiter #(
  parameter int WR_LOW_CYCLES  = 2,
  parameter int WR_HIGH_CYCLES = 2,
  parameter int PX_TIMEOUT     = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  input  logic        cmd_rs,
  input  logic [15:0] cmd_data,
  output logic        cmd_ready,
  input  logic        px_valid,
  input  logic [15:0] px_data,
  input  logic        px_last,
  output logic        px_ready,
  output logic        lt24_cs_n,
  output logic        lt24_rs,
  output logic        lt24_rd_n,
  output logic        lt24_wr_n,
  output logic [15:0] lt24_data,
  output logic        frame_lock,
  output logic        frame_done,
  output logic        px_abort
);

  typedef enum logic [1:0] {IDLE, WR_LOW, WR_HIGH, GAP} state_t;

  localparam int LW = $clog2((WR_LOW_CYCLES  > 2) ? WR_LOW_CYCLES  : 2) + 1;
  localparam int HW = $clog2((WR_HIGH_CYCLES > 2) ? WR_HIGH_CYCLES : 2) + 1;
  localparam int GW = $clog2((PX_TIMEOUT     > 2) ? PX_TIMEOUT     : 2) + 1;
  localparam logic [LW-1:0] LOW_LAST  = LW'(WR_LOW_CYCLES - 1);
  localparam logic [HW-1:0] HIGH_LAST = HW'(WR_HIGH_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST  = (PX_TIMEOUT == 0) ? '0 : GW'(PX_TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_MAX   = '1;

  state_t        state;
  logic          owner_px;
  logic          beat_last;
  logic          armed;
  logic [LW-1:0] low_cnt;
  logic [HW-1:0] high_cnt;
  logic [GW-1:0] gap_cnt;

  logic high_done, px_next_ok, en, cmd_acc, px_acc;

  // armed keeps both readies low for the first cycle after reset.
  always_comb begin
    en         = reset_n && armed;
    high_done  = (state == WR_HIGH) && (high_cnt == HIGH_LAST);
    px_next_ok = high_done && owner_px && !beat_last;
    cmd_ready  = en && (state == IDLE) && !frame_lock && cmd_valid;
    px_ready   = en && (((state == IDLE) && !frame_lock && !cmd_valid && px_valid) ||
                        px_next_ok || (state == GAP));
    cmd_acc    = cmd_valid && cmd_ready;
    px_acc     = px_valid && px_ready;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      owner_px   <= 1'b0;
      beat_last  <= 1'b0;
      armed      <= 1'b0;
      low_cnt    <= '0;
      high_cnt   <= '0;
      gap_cnt    <= '0;
      lt24_cs_n  <= 1'b1;
      lt24_wr_n  <= 1'b1;
      lt24_rd_n  <= 1'b1;
      lt24_rs    <= 1'b1;
      lt24_data  <= '0;
      frame_lock <= 1'b0;
      frame_done <= 1'b0;
      px_abort   <= 1'b0;
    end else begin
      armed      <= 1'b1;
      lt24_rd_n  <= 1'b1;
      frame_done <= 1'b0;
      px_abort   <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_acc) begin
            state     <= WR_LOW;
            owner_px  <= 1'b0;
            low_cnt   <= '0;
            lt24_cs_n <= 1'b0;
            lt24_wr_n <= 1'b0;
            lt24_rs   <= cmd_rs;
            lt24_data <= cmd_data;
          end else if (px_acc) begin
            state      <= WR_LOW;
            owner_px   <= 1'b1;
            beat_last  <= px_last;
            low_cnt    <= '0;
            frame_lock <= 1'b1;
            lt24_cs_n  <= 1'b0;
            lt24_wr_n  <= 1'b0;
            lt24_rs    <= 1'b1;
            lt24_data  <= px_data;
          end
        end
        WR_LOW: begin
          if (low_cnt == LOW_LAST) begin
            state     <= WR_HIGH;
            low_cnt   <= '0;
            high_cnt  <= '0;
            lt24_wr_n <= 1'b1;
          end else begin
            low_cnt <= low_cnt + LW'(1);
          end
        end
        WR_HIGH: begin
          if (high_cnt != HIGH_LAST) begin
            high_cnt <= high_cnt + HW'(1);
          end else begin
            high_cnt <= '0;
            if (!owner_px) begin
              state     <= IDLE;
              lt24_cs_n <= 1'b1;
            end else if (beat_last) begin
              state      <= IDLE;
              lt24_cs_n  <= 1'b1;
              frame_lock <= 1'b0;
              frame_done <= 1'b1;
            end else if (px_acc) begin
              // back-to-back beat: cs_n stays low, straight into the next strobe
              state     <= WR_LOW;
              beat_last <= px_last;
              low_cnt   <= '0;
              lt24_wr_n <= 1'b0;
              lt24_data <= px_data;
            end else begin
              state   <= GAP;
              gap_cnt <= '0;
            end
          end
        end
        GAP: begin
          if (px_acc) begin
            state     <= WR_LOW;
            beat_last <= px_last;
            low_cnt   <= '0;
            gap_cnt   <= '0;
            lt24_wr_n <= 1'b0;
            lt24_data <= px_data;
          end else if (PX_TIMEOUT != 0 && gap_cnt == GAP_LAST) begin
            state      <= IDLE;
            gap_cnt    <= '0;
            lt24_cs_n  <= 1'b1;
            frame_lock <= 1'b0;
            px_abort   <= 1'b1;
          end else if (gap_cnt != GAP_MAX) begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lt24_bus_arbiter.sv
// Directed bench for lt24_bus_arbiter: expected bus words queued at stimulus time,
// compared against strobes captured by a monitor; timing checked with assertions.
module tb_lt24_bus_arbiter;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic cmd_valid = 1'b0, cmd_rs = 1'b0, px_valid = 1'b0, px_last = 1'b0;
  logic [15:0] cmd_data = '0, px_data = '0;

  logic cmd_ready, px_ready, cs_n, rs, rd_n, wr_n, lock, done, abort;
  logic cmd_ready0, px_ready0, cs_n0, rs0, rd_n0, wr_n0, lock0, done0, abort0;
  logic [15:0] data, data0;

  always #5 clk = ~clk;

  lt24_bus_arbiter #(.WR_LOW_CYCLES(2), .WR_HIGH_CYCLES(2), .PX_TIMEOUT(8)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_rs(cmd_rs),
    .cmd_data(cmd_data), .cmd_ready(cmd_ready), .px_valid(px_valid), .px_data(px_data),
    .px_last(px_last), .px_ready(px_ready), .lt24_cs_n(cs_n), .lt24_rs(rs),
    .lt24_rd_n(rd_n), .lt24_wr_n(wr_n), .lt24_data(data), .frame_lock(lock),
    .frame_done(done), .px_abort(abort));

  lt24_bus_arbiter #(.WR_LOW_CYCLES(2), .WR_HIGH_CYCLES(2), .PX_TIMEOUT(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_rs(cmd_rs),
    .cmd_data(cmd_data), .cmd_ready(cmd_ready0), .px_valid(px_valid), .px_data(px_data),
    .px_last(px_last), .px_ready(px_ready0), .lt24_cs_n(cs_n0), .lt24_rs(rs0),
    .lt24_rd_n(rd_n0), .lt24_wr_n(wr_n0), .lt24_data(data0), .frame_lock(lock0),
    .frame_done(done0), .px_abort(abort0));

  // Which instance the handshakes and the monitor follow.
  logic sel0 = 1'b0;
  logic m_cmd_ready, m_px_ready, m_cs_n, m_rs, m_wr_n, m_lock, m_done, m_abort;
  logic [15:0] m_data;
  assign m_cmd_ready = sel0 ? cmd_ready0 : cmd_ready;
  assign m_px_ready  = sel0 ? px_ready0  : px_ready;
  assign m_cs_n      = sel0 ? cs_n0      : cs_n;
  assign m_rs        = sel0 ? rs0        : rs;
  assign m_wr_n      = sel0 ? wr_n0      : wr_n;
  assign m_data      = sel0 ? data0      : data;
  assign m_lock      = sel0 ? lock0      : lock;
  assign m_done      = sel0 ? done0      : done;
  assign m_abort     = sel0 ? abort0     : abort;

  // Monitor: samples 3 time units after each rising edge.
  int mon_cyc = 0, fall_n = 0, done_n = 0, done_cyc = 0, abort_n = 0, lock_cs_hi = 0;
  int fall_cyc [0:255];
  logic [16:0] obs [0:255];
  logic prev_wr = 1'b1;
  initial forever begin
    @(posedge clk);
    #3;
    mon_cyc++;
    if (prev_wr === 1'b1 && m_wr_n === 1'b0 && fall_n < 256) begin
      obs[fall_n] = {m_rs, m_data};
      fall_cyc[fall_n] = mon_cyc;
      fall_n++;
    end
    prev_wr = m_wr_n;
    if (m_done === 1'b1) begin done_n++; done_cyc = mon_cyc; end
    if (m_abort === 1'b1) abort_n++;
    if (m_lock === 1'b1 && m_cs_n === 1'b1) lock_cs_hi++;
  end

  int n_chk = 0, n_pass = 0, rd_ptr = 0;
  logic [16:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_chk++;
    assert (o === e) n_pass++;
    else $error("FAIL %s: got %0h, want %0h", tag, o, e);
  endtask

  task automatic sb_drain(input string tag);
    logic [16:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (rd_ptr < fall_n) begin
        chk(tag, {15'd0, obs[rd_ptr]}, {15'd0, e});
        rd_ptr++;
      end else begin
        chk({tag, "_missing"}, fall_n, rd_ptr + 1);
      end
    end
    chk({tag, "_count"}, fall_n, rd_ptr);
  endtask

  task automatic cmd_xfer(input logic r, input logic [15:0] d);
    logic acc = 1'b0;
    cmd_valid = 1'b1; cmd_rs = r; cmd_data = d;
    exp_q.push_back({r, d});
    for (int i = 0; i < 60 && !acc; i++) begin
      #1;
      if (m_cmd_ready === 1'b1) acc = 1'b1;
      @(negedge clk);
    end
    chk("cmd_accept", acc, 1'b1);
  endtask

  task automatic px_beat(input logic [15:0] d, input logic last);
    logic acc = 1'b0;
    px_valid = 1'b1; px_data = d; px_last = last;
    exp_q.push_back({1'b1, d});
    for (int i = 0; i < 60 && !acc; i++) begin
      #1;
      if (m_px_ready === 1'b1) acc = 1'b1;
      @(negedge clk);
    end
    chk("px_accept", acc, 1'b1);
  endtask

  initial begin
    int f0, d0, a0, seen;
    logic got;

    // Reset values, with requests asserted during reset.
    repeat (3) @(negedge clk);
    cmd_valid = 1'b1; px_valid = 1'b1;
    #1;
    chk("rst_cs_n", cs_n, 1'b1);
    chk("rst_wr_n", wr_n, 1'b1);
    chk("rst_rd_n", rd_n, 1'b1);
    chk("rst_rd_n0", rd_n0, 1'b1);
    chk("rst_rs", rs, 1'b1);
    chk("rst_data", data, 16'h0);
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_px_ready", px_ready, 1'b0);
    chk("rst_lock", lock, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_abort", abort, 1'b0);
    @(negedge clk);
    cmd_valid = 1'b0; px_valid = 1'b0;
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // Single command timing, second command held pending.
    cmd_valid = 1'b1; cmd_rs = 1'b0; cmd_data = 16'h002C;
    exp_q.push_back({1'b0, 16'h002C});
    #1;
    chk("c1_ready", cmd_ready, 1'b1);
    @(negedge clk);
    cmd_rs = 1'b1; cmd_data = 16'h1234;
    exp_q.push_back({1'b1, 16'h1234});
    for (int k = 1; k <= 5; k++) begin
      if (k > 1) @(negedge clk);
      #1;
      chk($sformatf("c1_cs_n_%0d", k), cs_n, (k == 5));
      chk($sformatf("c1_wr_n_%0d", k), wr_n, (k >= 3));
      chk($sformatf("c1_ready_%0d", k), cmd_ready, (k == 5));
      if (k < 5) begin
        chk($sformatf("c1_data_%0d", k), data, 16'h002C);
        chk($sformatf("c1_rs_%0d", k), rs, 1'b0);
      end
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (6) @(negedge clk);
    sb_drain("cmd_words");
    chk("cmd_period", fall_cyc[1] - fall_cyc[0], 5);

    // Back-to-back 4-pixel frame.
    f0 = fall_n; d0 = done_n;
    px_beat(16'h1111, 1'b0);
    chk("frm_lock_on", lock, 1'b1);
    px_beat(16'h2222, 1'b0);
    px_beat(16'h3333, 1'b0);
    px_beat(16'h4444, 1'b1);
    px_valid = 1'b0;
    repeat (6) @(negedge clk);
    sb_drain("frm_words");
    for (int i = 0; i < 3; i++)
      chk($sformatf("frm_spacing_%0d", i), fall_cyc[f0+i+1] - fall_cyc[f0+i], 4);
    chk("frm_done_n", done_n - d0, 1);
    chk("frm_done_cyc", done_cyc - fall_cyc[f0+3], 4);
    chk("frm_lock_off", lock, 1'b0);

    // Collision in the same IDLE cycle: command first.
    f0 = fall_n; d0 = done_n;
    cmd_valid = 1'b1; cmd_rs = 1'b0; cmd_data = 16'h0029;
    px_valid = 1'b1; px_data = 16'hAAAA; px_last = 1'b1;
    #1;
    chk("col_cmd_ready", cmd_ready, 1'b1);
    chk("col_px_ready", px_ready, 1'b0);
    exp_q.push_back({1'b0, 16'h0029});
    @(negedge clk);
    cmd_valid = 1'b0;
    px_beat(16'hAAAA, 1'b1);
    px_valid = 1'b0;
    repeat (6) @(negedge clk);
    sb_drain("col_words");
    chk("col_px_after_cmd", fall_cyc[f0+1] - fall_cyc[f0], 5);
    chk("col_done", done_n - d0, 1);

    // Command raised mid-frame waits for frame_done.
    f0 = fall_n; d0 = done_n;
    px_beat(16'h0B01, 1'b0);
    cmd_valid = 1'b1; cmd_rs = 1'b0; cmd_data = 16'h002A;
    px_beat(16'h0B02, 1'b0);
    chk("mid_ready_lock", cmd_ready, 1'b0);
    px_beat(16'h0B03, 1'b1);
    px_valid = 1'b0;
    exp_q.push_back({1'b0, 16'h002A});
    seen = 0; got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk); #1;
      if (done_n != d0) got = 1'b1;
      else if (cmd_ready === 1'b1) seen++;
    end
    chk("mid_done_seen", got, 1'b1);
    chk("mid_ready_early", seen, 0);
    chk("mid_ready_at_done", cmd_ready, 1'b1);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (6) @(negedge clk);
    sb_drain("mid_words");
    chk("mid_cmd_cyc", fall_cyc[f0+3] - done_cyc, 1);

    // Underrun shorter than the timeout: frame resumes.
    d0 = done_n; a0 = abort_n;
    px_beat(16'h0C01, 1'b0);
    px_beat(16'h0C02, 1'b0);
    px_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 40 && seen < 6; i++) begin
      @(negedge clk); #1;
      if (px_ready === 1'b1) begin
        seen++;
        if (seen > 1) begin
          chk("gap_cs_n", cs_n, 1'b0);
          chk("gap_wr_n", wr_n, 1'b1);
        end
      end
    end
    px_beat(16'h0C03, 1'b1);
    px_valid = 1'b0;
    repeat (6) @(negedge clk);
    sb_drain("gap_words");
    chk("gap_done", done_n - d0, 1);
    chk("gap_no_abort", abort_n - a0, 0);

    // Underrun reaching the timeout: abort, no frame_done.
    d0 = done_n; a0 = abort_n;
    px_beat(16'h0D01, 1'b0);
    px_beat(16'h0D02, 1'b0);
    px_valid = 1'b0;
    seen = 0; got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk); #1;
      if (abort_n != a0) got = 1'b1;
      else if (px_ready === 1'b1) seen++;
    end
    chk("abt_seen", got, 1'b1);
    chk("abt_gap_len", seen, 9);
    chk("abt_cs_n", cs_n, 1'b1);
    chk("abt_lock", lock, 1'b0);
    @(negedge clk);
    cmd_xfer(1'b0, 16'h0011);
    cmd_valid = 1'b0;
    repeat (6) @(negedge clk);
    sb_drain("abt_words");
    chk("abt_pulse", abort_n - a0, 1);
    chk("abt_no_done", done_n - d0, 0);

    // Reset during WR_LOW; pending requests re-accepted afterward.
    cmd_valid = 1'b1; cmd_rs = 1'b0; cmd_data = 16'h00AB;
    exp_q.push_back({1'b0, 16'h00AB});
    #1;
    chk("rsm_ready", cmd_ready, 1'b1);
    @(negedge clk);
    reset_n = 1'b0;
    px_valid = 1'b1; px_data = 16'h7777; px_last = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rsm_cs_n", cs_n, 1'b1);
    chk("rsm_wr_n", wr_n, 1'b1);
    chk("rsm_data", data, 16'h0);
    chk("rsm_lock", lock, 1'b0);
    chk("rsm_cmd_ready", cmd_ready, 1'b0);
    chk("rsm_px_ready", px_ready, 1'b0);
    @(negedge clk);
    cmd_xfer(1'b0, 16'h00AB);
    cmd_valid = 1'b0;
    px_beat(16'h7777, 1'b1);
    px_valid = 1'b0;
    repeat (6) @(negedge clk);
    sb_drain("rsm_words");

    // PX_TIMEOUT=0 instance: single-pixel frame, then a long gap.
    sel0 = 1'b1;
    f0 = fall_n; d0 = done_n;
    px_beat(16'h5A5A, 1'b1);
    px_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("one_strobes", fall_n - f0, 1);
    chk("one_done", done_n - d0, 1);
    chk("one_lock", lock0, 1'b0);
    d0 = done_n; a0 = abort_n;
    px_beat(16'h0E01, 1'b0);
    px_valid = 1'b0;
    repeat (5000) @(negedge clk);
    chk("long_no_abort", abort_n - a0, 0);
    chk("long_lock", lock0, 1'b1);
    chk("long_cs_n", cs_n0, 1'b0);
    chk("long_wr_n", wr_n0, 1'b1);
    px_beat(16'h0E02, 1'b0);
    px_beat(16'h0E03, 1'b1);
    px_valid = 1'b0;
    repeat (6) @(negedge clk);
    sb_drain("long_words");
    chk("long_done", done_n - d0, 1);
    chk("lock_cs_high", lock_cs_hi, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
